// File: rtl/acq_pkg.sv
// Shared definitions for the data acquisition front-end.
// Holds the FSM state encoding, the default sample width and the sample type
// used by data_acquire and moving_avg.
package acq_pkg;

  localparam int DATA_W_DEF = 12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    CALC = 3'd3,
    OUT  = 3'd4
  } acq_state_e;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

endpackage : acq_pkg

// File: rtl/moving_avg.sv
// Moving-average filter over 2^AVG_LOG2 signed samples.
// Keeps a circular history buffer and a running sum; each valid sample
// replaces the oldest entry and updates the sum in a single cycle.
// Ports:
//   clk_i     - clock, rising edge
//   reset_n_i - asynchronous active-low reset, clears history/sum/pointer
//   valid_i   - one-cycle strobe: fold sample_i into the average
//   sample_i  - signed sample
//   result_o  - running sum >>> AVG_LOG2 (rounds toward minus infinity)
module moving_avg
  import acq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     valid_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] result_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  // Keep at least one pointer bit so the passthrough case stays legal.
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic signed [DATA_W-1:0] hist_q [DEPTH];
  logic        [PTR_W-1:0]  ptr_q;
  logic        [PTR_W-1:0]  ptr_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  // Next running sum and write pointer for an incoming sample.
  always_comb begin
    acc_d = acc_q;
    ptr_d = ptr_q;
    if (valid_i) begin
      // Size casts of signed operands sign-extend to the accumulator width.
      acc_d = acc_q - ACC_W'(hist_q[ptr_q]) + ACC_W'(sample_i);
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr_q + PTR_W'(1);
    end else begin
      acc_d = acc_q;
      ptr_d = ptr_q;
    end
  end

  // History buffer, pointer and accumulator registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_q[i] <= {DATA_W{1'b0}};
      end
      ptr_q <= {PTR_W{1'b0}};
      acc_q <= {ACC_W{1'b0}};
    end else begin
      if (valid_i) begin
        hist_q[ptr_q] <= sample_i;
      end
      ptr_q <= ptr_d;
      acc_q <= acc_d;
    end
  end

  // The mean of DATA_W-bit samples always fits back into DATA_W bits.
  assign result_o = DATA_W'(acc_q >>> AVG_LOG2);

endmodule : moving_avg

// File: rtl/data_acquire.sv
// Acquisition front-end: on a falling edge of syncro_i it pulses a conversion
// request to the ADC, waits (bounded by TIMEOUT) for a fresh rising edge of
// the ADC ready line, captures the sample, filters it through moving_avg and
// presents the result with a one-cycle data_rdy_o pulse.
// Ports:
//   clk_i          - clock, rising edge
//   reset_n_i      - asynchronous active-low reset
//   adc_data_req_o - conversion request, high for REQ_LEN cycles
//   adc_data_rdy_i - ADC ready level; its rising edge marks valid data
//   adc_data_i     - signed ADC sample
//   syncro_i       - sync strobe level; its falling edge starts a conversion
//   data_o         - filtered signed sample, held between updates
//   data_rdy_o     - one-cycle pulse when data_o is updated
module data_acquire
  import acq_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = 3,
  parameter int REQ_LEN  = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  output logic              adc_data_req_o,
  input  logic              adc_data_rdy_i,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              syncro_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_rdy_o
);

  localparam int CNT_MAX = (TIMEOUT > REQ_LEN) ? TIMEOUT : REQ_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  acq_state_e               state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     syncro_q;
  logic                     rdy_q;
  logic signed [DATA_W-1:0] sample_q;
  logic                     req_q;
  logic [DATA_W-1:0]        data_q;
  logic                     drdy_q;
  logic                     sync_fall_s;
  logic                     rdy_rise_s;
  logic                     calc_s;
  logic signed [DATA_W-1:0] result_s;

  assign sync_fall_s = syncro_q & ~syncro_i;
  assign rdy_rise_s  = adc_data_rdy_i & ~rdy_q;
  assign calc_s      = (state_q == CALC);

  // Acquisition FSM with edge-detect delays, shared request/timeout counter
  // and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      syncro_q <= 1'b0;
      rdy_q    <= 1'b0;
      sample_q <= {DATA_W{1'b0}};
      req_q    <= 1'b0;
      data_q   <= {DATA_W{1'b0}};
      drdy_q   <= 1'b0;
    end else begin
      syncro_q <= syncro_i;
      rdy_q    <= adc_data_rdy_i;
      drdy_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync_fall_s) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            cnt_q   <= {CNT_W{1'b0}};
          end
        end
        REQ: begin
          if (cnt_q == CNT_W'(REQ_LEN - 1)) begin
            state_q <= WAIT;
            req_q   <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT: begin
          // Only a fresh edge is accepted; a level already high is ignored.
          if (rdy_rise_s) begin
            sample_q <= adc_data_i;
            state_q  <= CALC;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        CALC: begin
          state_q <= OUT;
        end
        OUT: begin
          data_q  <= result_s;
          drdy_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  moving_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_moving_avg (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .valid_i   (calc_s),
    .sample_i  (sample_q),
    .result_o  (result_s)
  );

  assign adc_data_req_o = req_q;
  assign data_o         = data_q;
  assign data_rdy_o     = drdy_q;

endmodule : data_acquire

// File: tb/tb_data_acquire.sv
// Directed bench for data_acquire: an averaging instance (AVG_LOG2=3) and a
// passthrough instance (AVG_LOG2=0) share all inputs.
module tb_data_acquire;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              syncro;
  logic              rdy;
  logic signed [11:0] adc;
  logic              req0, req1, drdy0, drdy1;
  logic signed [11:0] d0, d1;

  int tests = 0;
  int fails = 0;
  int req_hi0 = 0;
  int drdy_cnt0 = 0;
  int drdy_cnt1 = 0;

  int samp [9] = '{-512, 312, 157, -200, 700, -20, 920, 820, 1020};
  int exp0 [9] = '{-64, -25, -6, -31, 57, 54, 169, 272, 463};

  always #5 clk = ~clk;

  data_acquire #(.DATA_W(12), .AVG_LOG2(3), .REQ_LEN(2), .TIMEOUT(64)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .adc_data_req_o(req0), .adc_data_rdy_i(rdy),
    .adc_data_i(adc), .syncro_i(syncro), .data_o(d0), .data_rdy_o(drdy0));

  data_acquire #(.DATA_W(12), .AVG_LOG2(0), .REQ_LEN(2), .TIMEOUT(64)) dut1 (
    .clk_i(clk), .reset_n_i(reset_n), .adc_data_req_o(req1), .adc_data_rdy_i(rdy),
    .adc_data_i(adc), .syncro_i(syncro), .data_o(d1), .data_rdy_o(drdy1));

  // Count request-high cycles and output pulses seen at each rising edge.
  always @(posedge clk) begin
    if (req0) req_hi0 = req_hi0 + 1;
    if (drdy0) drdy_cnt0 = drdy_cnt0 + 1;
    if (drdy1) drdy_cnt1 = drdy_cnt1 + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sync pulse, then wait (bounded) for the request to rise and fall.
  task automatic sync_and_req(input string tag);
    int n;
    syncro = 1'b1;
    repeat (5) @(negedge clk);
    syncro = 1'b0;
    n = 0;
    while (!req0 && n < 8) begin @(negedge clk); n++; end
    chk({tag, " req_rise"}, int'(req0), 1);
    n = 0;
    while (req0 && n < 8) begin @(negedge clk); n++; end
    chk({tag, " req_fall"}, int'(req0), 0);
    chk({tag, " req_len"}, req_hi0, 2);
  endtask

  task automatic conv(input string tag, input int s, input int e0, input int e1,
                      input bit held, input bit keep, input bit toggle);
    req_hi0 = 0; drdy_cnt0 = 0; drdy_cnt1 = 0;
    sync_and_req(tag);
    if (toggle) begin
      syncro = 1'b1;
      repeat (3) @(negedge clk);
      syncro = 1'b0;
      @(negedge clk);
    end
    if (held) begin
      repeat (10) @(negedge clk);
      chk({tag, " no_capture_while_held"}, drdy_cnt0, 0);
      rdy = 1'b0;
      @(negedge clk);
    end
    adc = 12'(s);
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, " drdy0"}, int'(drdy0), 1);
    chk({tag, " data0"}, int'(d0), e0);
    chk({tag, " drdy1"}, int'(drdy1), 1);
    chk({tag, " data1"}, int'(d1), e1);
    @(negedge clk);
    chk({tag, " drdy0_single"}, int'(drdy0), 0);
    if (!keep) rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, " one_pulse"}, drdy_cnt0, 1);
    chk({tag, " no_extra_req"}, req_hi0, 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset_n = 1'b0; syncro = 1'b0; rdy = 1'b0; adc = 12'sd0;
    repeat (2) @(negedge clk);
    chk("rst req", int'(req0), 0);
    chk("rst drdy", int'(drdy0), 0);
    chk("rst data0", int'(d0), 0);
    chk("rst data1", int'(d1), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Make data_o nonzero, then reset in the middle of a request.
    conv("pre", 333, 41, 333, 1'b0, 1'b0, 1'b0);
    syncro = 1'b1;
    repeat (3) @(negedge clk);
    syncro = 1'b0;
    n = 0;
    while (!req0 && n < 8) begin @(negedge clk); n++; end
    chk("midrst req_before", int'(req0), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst req", int'(req0), 0);
    chk("midrst drdy", int'(drdy0), 0);
    chk("midrst data0", int'(d0), 0);
    chk("midrst data1", int'(d1), 0);
    @(negedge clk);
    reset_n = 1'b1;
    req_hi0 = 0;
    repeat (10) @(negedge clk);
    chk("post_rst no_req", req_hi0, 0);

    // Filter warm-up and steady state from cleared history.
    for (int i = 0; i < 9; i++) begin
      conv($sformatf("seq%0d", i), samp[i], exp0[i], samp[i], 1'b0, (i == 8), 1'b0);
    end

    // Ready still high from the previous conversion: needs a fresh edge.
    conv("held", 100, 437, 100, 1'b1, 1'b0, 1'b0);

    // No ready at all: times out, no output change.
    req_hi0 = 0; drdy_cnt0 = 0; drdy_cnt1 = 0;
    sync_and_req("tmo");
    repeat (70) @(negedge clk);
    chk("tmo no_drdy0", drdy_cnt0, 0);
    chk("tmo no_drdy1", drdy_cnt1, 0);
    chk("tmo data0", int'(d0), 437);
    chk("tmo data1", int'(d1), 100);
    chk("tmo single_req", req_hi0, 2);

    // Back in IDLE; sync edges during WAIT are ignored.
    conv("after_tmo", -200, 392, -200, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_data_acquire
